// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over a req/ack handshake, stalling upstream until the access completes.
// Optional ack timeout with a sticky error flag is enabled by defining MEM_ACK_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] ALU_Res_i,
  input  logic [31:0] MemWrite_Data_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] ALU_Res_o,
  output logic [31:0] MemRead_Data_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [4:0]  rd_lat_q;
  logic        rw_lat_q, m2r_lat_q;
  logic [31:0] alu_res_q, rdata_q;
  logic [4:0]  rdaddr_q;
  logic        regwrite_q, memtoreg_q;
  logic        mem_op, timeout, done;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  assign mem_op = MemRead_i | MemWrite_i;
  assign done   = (state_q == ACCESS) && (mem_ack_i || timeout);

`ifdef MEM_ACK_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  // Timeout fires on the ACCESS cycle that would bring the count to TIMEOUT_CYCLES; a same-cycle ack wins.
  assign timeout = (state_q == ACCESS) && !mem_ack_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= 8'd0;
      end else if (!mem_ack_i) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Stall covers the issue cycle and every ACCESS cycle except the completing one.
  assign stall_o = ((state_q == IDLE) && start_i && mem_op) || ((state_q == ACCESS) && !done);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rd_lat_q    <= 5'd0;
      rw_lat_q    <= 1'b0;
      m2r_lat_q   <= 1'b0;
      alu_res_q   <= 32'd0;
      rdata_q     <= 32'd0;
      rdaddr_q    <= 5'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (mem_op) begin
              state_q     <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= MemWrite_i;
              mem_addr_q  <= ALU_Res_i;
              mem_wdata_q <= MemWrite_Data_i;
              rd_lat_q    <= RDaddr_i;
              rw_lat_q    <= RegWrite_i;
              m2r_lat_q   <= MemtoReg_i;
              regwrite_q  <= 1'b0;
            end else begin
              alu_res_q  <= ALU_Res_i;
              rdaddr_q   <= RDaddr_i;
              regwrite_q <= RegWrite_i;
              memtoreg_q <= MemtoReg_i;
            end
          end
        end
        ACCESS: begin
          if (done) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            alu_res_q  <= mem_addr_q;
            rdaddr_q   <= rd_lat_q;
            regwrite_q <= rw_lat_q;
            memtoreg_q <= m2r_lat_q;
            if (!mem_we_q) begin
              rdata_q <= mem_ack_i ? mem_rdata_i : 32'd0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign ALU_Res_o      = alu_res_q;
  assign MemRead_Data_o = rdata_q;
  assign RDaddr_o       = rdaddr_q;
  assign RegWrite_o     = regwrite_q;
  assign MemtoReg_o     = memtoreg_q;

endmodule
